// File: rtl/ripple_count_extender_if.sv
// Bundle of the data, control and snapshot signals of the ripple count
// extender. The master side (the stage that feeds count_in and consumes
// snapshots) drives the inputs. The slave side (the extender) drives the
// outputs. dbg_state carries the tracking FSM state for observation.
//
// Snapshot handshake: snap_valid/snap_data are offered by the slave. A
// transfer happens on a rising clk edge where snap_valid and snap_ready are
// both 1. While snap_valid is 1 and snap_ready is 0, snap_valid and
// snap_data hold steady. snap_ready may be driven independently of
// snap_valid.
interface ripple_count_extender_if #(
  parameter int IN_WIDTH  = 4,
  parameter int EXT_WIDTH = 16
);
  logic [IN_WIDTH-1:0]  count_in;
  logic                 clear;
  logic [EXT_WIDTH-1:0] match_value;
  logic [EXT_WIDTH-1:0] total;
  logic                 wrap_pulse;
  logic                 match_pulse;
  logic                 overflow;
  logic                 snap_valid;
  logic                 snap_ready;
  logic [EXT_WIDTH-1:0] snap_data;
  logic                 dbg_state;

  modport master (
    output count_in,
    output clear,
    output match_value,
    output snap_ready,
    input  total,
    input  wrap_pulse,
    input  match_pulse,
    input  overflow,
    input  snap_valid,
    input  snap_data,
    input  dbg_state
  );

  modport slave (
    input  count_in,
    input  clear,
    input  match_value,
    input  snap_ready,
    output total,
    output wrap_pulse,
    output match_pulse,
    output overflow,
    output snap_valid,
    output snap_data,
    output dbg_state
  );
endinterface

// File: rtl/ripple_count_extender.sv
// Ripple count extender: brings an asynchronously settling ripple counter
// value into the clk domain. It rejects ripple transients with a stability
// filter. It accumulates modulo increments into a wide total and reports
// wrap, overflow and match events. Snapshots of the total are offered over
// a valid/ready handshake.
module ripple_count_extender #(
  parameter int IN_WIDTH      = 4,
  parameter int EXT_WIDTH     = 16,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  ripple_count_extender_if.slave  bus
);

  // Counter wide enough to hold STABLE_CYCLES itself (saturation value).
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] STABLE_ONE = CW'(1);

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Synchroniser and stability filter state.
  logic [IN_WIDTH-1:0] s1;
  logic [IN_WIDTH-1:0] s2;
  logic [IN_WIDTH-1:0] cand;
  logic [CW-1:0]       stab_cnt;

  // Tracking state and registered outputs.
  state_t               state;
  logic [IN_WIDTH-1:0]  last_val;
  logic [EXT_WIDTH-1:0] total;
  logic                 wrap_pulse;
  logic                 match_pulse;
  logic                 overflow;
  logic                 snap_valid;
  logic [EXT_WIDTH-1:0] snap_data;

  // Combinational helpers.
  logic [CW-1:0]        stab_next;
  logic                 accept;
  logic                 update;
  logic [IN_WIDTH-1:0]  delta;
  logic [EXT_WIDTH:0]   sum_wide;
  logic [EXT_WIDTH-1:0] new_total;
  logic                 carry;

  // Stability filter: next counter value, and the single accept strobe
  // issued when a candidate's counter first reaches STABLE_CYCLES.
  always_comb begin
    stab_next = stab_cnt;
    accept    = 1'b0;
    if (s2 != cand) begin
      stab_next = STABLE_ONE;
    end else if (stab_cnt != STABLE_MAX) begin
      stab_next = stab_cnt + STABLE_ONE;
    end
    accept = (stab_next == STABLE_MAX) &&
             ((s2 != cand) || (stab_cnt != STABLE_MAX));
  end

  // Accumulation datapath: modulo step from last accepted value, wide add
  // with a carry-out for overflow detection.
  always_comb begin
    delta     = s2 - last_val;
    sum_wide  = {1'b0, total} + {{(EXT_WIDTH + 1 - IN_WIDTH){1'b0}}, delta};
    new_total = sum_wide[EXT_WIDTH-1:0];
    carry     = sum_wide[EXT_WIDTH];
    update    = accept && (state == TRACK) && (s2 != last_val);
  end

  // Two-flop synchroniser followed by the candidate/stability registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      cand     <= '0;
      stab_cnt <= '0;
    end else begin
      s1       <= bus.count_in;
      s2       <= s1;
      cand     <= s2;
      stab_cnt <= stab_next;
    end
  end

  // Tracking FSM with total, event flags and snapshot handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PRIME;
      last_val    <= '0;
      total       <= '0;
      wrap_pulse  <= 1'b0;
      match_pulse <= 1'b0;
      overflow    <= 1'b0;
      snap_valid  <= 1'b0;
      snap_data   <= '0;
    end else begin
      wrap_pulse  <= 1'b0;
      match_pulse <= 1'b0;

      // A completed transfer retires the snapshot unless an update below
      // immediately replaces it.
      if (snap_valid && bus.snap_ready) begin
        snap_valid <= 1'b0;
      end

      if (bus.clear) begin
        // Clear dominates any concurrent update; the filter keeps running
        // and the pending snapshot is left alone.
        total    <= '0;
        overflow <= 1'b0;
        state    <= PRIME;
      end else begin
        case (state)
          PRIME: begin
            if (accept) begin
              last_val <= s2;
              state    <= TRACK;
            end
          end
          TRACK: begin
            if (update) begin
              total       <= new_total;
              last_val    <= s2;
              wrap_pulse  <= (s2 < last_val);
              match_pulse <= (new_total == bus.match_value) &&
                             (total != bus.match_value);
              if (carry) begin
                overflow <= 1'b1;
              end
              // A snapshot is only taken when the slot is free or being
              // drained this cycle; otherwise this update's snapshot is lost.
              if (!snap_valid || bus.snap_ready) begin
                snap_data  <= new_total;
                snap_valid <= 1'b1;
              end
            end
          end
          default: begin
            state <= PRIME;
          end
        endcase
      end
    end
  end

  assign bus.total       = total;
  assign bus.wrap_pulse  = wrap_pulse;
  assign bus.match_pulse = match_pulse;
  assign bus.overflow    = overflow;
  assign bus.snap_valid  = snap_valid;
  assign bus.snap_data   = snap_data;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_ripple_count_extender.sv
// Directed bench for ripple_count_extender. A 16-bit and an 8-bit instance
// share all stimulus, so the 8-bit one exercises the overflow boundary.
module tb_ripple_count_extender;

  logic clk = 1'b0;
  logic rst;

  // Clock and reset.
  always #5 clk = ~clk;

  ripple_count_extender_if #(.IN_WIDTH(4), .EXT_WIDTH(16)) bus16 ();
  ripple_count_extender_if #(.IN_WIDTH(4), .EXT_WIDTH(8))  bus8 ();

  assign bus8.count_in    = bus16.count_in;
  assign bus8.clear       = bus16.clear;
  assign bus8.match_value = bus16.match_value[7:0];
  assign bus8.snap_ready  = bus16.snap_ready;

  ripple_count_extender #(.IN_WIDTH(4), .EXT_WIDTH(16), .STABLE_CYCLES(2)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  ripple_count_extender #(.IN_WIDTH(4), .EXT_WIDTH(8), .STABLE_CYCLES(2)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  int vecs = 0;
  int fails = 0;
  int wrap_seen = 0;
  int match_seen = 0;

  // Pulse counters on the 16-bit instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus16.wrap_pulse)  wrap_seen++;
      if (bus16.match_pulse) match_seen++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a new count just after an edge; return mid-cycle after the edge
  // on which a steady value is accepted (4th edge after the change).
  task automatic step(input logic [3:0] v);
    @(posedge clk);
    #1 bus16.count_in = v;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1 bus16.clear = 1'b1;
    @(posedge clk);
    #1 bus16.clear = 1'b0;
    @(negedge clk);
  endtask

  int          e16;
  int          d;
  logic [3:0]  dd;
  logic [3:0]  cur;

  initial begin
    rst                = 1'b1;
    bus16.count_in     = 4'd0;
    bus16.clear        = 1'b0;
    bus16.match_value  = 16'd10;
    bus16.snap_ready   = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_total",    32'(bus16.total),       32'd0);
    chk("rst_wrap",     32'(bus16.wrap_pulse),  32'd0);
    chk("rst_match",    32'(bus16.match_pulse), 32'd0);
    chk("rst_ovf",      32'(bus16.overflow),    32'd0);
    chk("rst_svalid",   32'(bus16.snap_valid),  32'd0);
    chk("rst_sdata",    32'(bus16.snap_data),   32'd0);
    chk("rst_state",    32'(bus16.dbg_state),   32'd0);

    @(posedge clk);
    #1 rst = 1'b0;
    settle(4);
    chk("prime_state",  32'(bus16.dbg_state),   32'd1);
    chk("prime_total",  32'(bus16.total),       32'd0);
    chk("prime_svalid", 32'(bus16.snap_valid),  32'd0);

    // Count 1..15, then 0; match_value is 10.
    for (int v = 1; v <= 15; v++) begin
      step(4'(v));
      chk("cnt_total",  32'(bus16.total),      32'(v));
      chk("cnt_sdata",  32'(bus16.snap_data),  32'(v));
      chk("cnt_svalid", 32'(bus16.snap_valid), 32'd1);
      chk("cnt_wrap",   32'(bus16.wrap_pulse), 32'd0);
      if (v == 10) chk("match_at_10", 32'(bus16.match_pulse), 32'd1);
      if (v == 11) chk("match_at_11", 32'(bus16.match_pulse), 32'd0);
      settle(3);
    end
    step(4'd0);
    chk("wrap_total", 32'(bus16.total),      32'd16);
    chk("wrap_pulse", 32'(bus16.wrap_pulse), 32'd1);
    chk("wrap_ovf",   32'(bus16.overflow),   32'd0);
    settle(3);
    chk("wrap_count",  32'(wrap_seen),        32'd1);
    chk("match_count", 32'(match_seen),       32'd1);
    chk("snap_drain",  32'(bus16.snap_valid), 32'd0);

    // Glitches around a held 5.
    step(4'd5);
    chk("five_total", 32'(bus16.total), 32'd21);
    settle(3);
    @(posedge clk);
    #2 bus16.count_in = 4'd7;
    #3 bus16.count_in = 4'd5;
    settle(6);
    chk("glitch_a_total",  32'(bus16.total),      32'd21);
    chk("glitch_a_svalid", 32'(bus16.snap_valid), 32'd0);
    @(posedge clk);
    #1 bus16.count_in = 4'd7;
    @(posedge clk);
    #1 bus16.count_in = 4'd5;
    settle(6);
    chk("glitch_b_total",  32'(bus16.total),      32'd21);
    chk("glitch_b_svalid", 32'(bus16.snap_valid), 32'd0);
    chk("glitch_b_wraps",  32'(wrap_seen),        32'd1);

    // Wide deltas: 5->14 adds 9, 14->3 adds 5 and wraps.
    step(4'd14);
    chk("wide_total", 32'(bus16.total),      32'd30);
    chk("wide_wrap",  32'(bus16.wrap_pulse), 32'd0);
    settle(3);
    step(4'd3);
    chk("wide2_total", 32'(bus16.total),      32'd35);
    chk("wide2_wrap",  32'(bus16.wrap_pulse), 32'd1);
    settle(3);

    // Clear, then the next accepted value only primes.
    pulse_clear();
    chk("clr_total", 32'(bus16.total),     32'd0);
    chk("clr_state", 32'(bus16.dbg_state), 32'd0);
    step(4'd4);
    chk("reprime_total", 32'(bus16.total),     32'd0);
    chk("reprime_state", 32'(bus16.dbg_state), 32'd1);
    settle(2);

    // Back-pressure: snapshot of total 1 is held over 3 updates.
    bus16.snap_ready = 1'b0;
    step(4'd5);
    chk("bp1_total", 32'(bus16.total),      32'd1);
    chk("bp1_valid", 32'(bus16.snap_valid), 32'd1);
    chk("bp1_data",  32'(bus16.snap_data),  32'd1);
    settle(3);
    step(4'd6);
    chk("bp2_total", 32'(bus16.total),      32'd2);
    chk("bp2_data",  32'(bus16.snap_data),  32'd1);
    settle(3);
    step(4'd7);
    chk("bp3_total", 32'(bus16.total),      32'd3);
    chk("bp3_valid", 32'(bus16.snap_valid), 32'd1);
    chk("bp3_data",  32'(bus16.snap_data),  32'd1);
    settle(3);
    @(posedge clk);
    #1 bus16.snap_ready = 1'b1;
    @(posedge clk);
    #1 bus16.snap_ready = 1'b0;
    @(negedge clk);
    chk("drain_valid", 32'(bus16.snap_valid), 32'd0);
    chk("drain_data",  32'(bus16.snap_data),  32'd1);

    // Clear on the same edge as an accepted update, with a pending snapshot.
    step(4'd8);
    chk("pend_valid", 32'(bus16.snap_valid), 32'd1);
    chk("pend_data",  32'(bus16.snap_data),  32'd4);
    settle(3);
    @(posedge clk);
    #1 bus16.count_in = 4'd10;
    repeat (3) @(posedge clk);
    #1 bus16.clear = 1'b1;
    @(posedge clk);
    #1 bus16.clear = 1'b0;
    @(negedge clk);
    chk("clrupd_total", 32'(bus16.total),      32'd0);
    chk("clrupd_state", 32'(bus16.dbg_state),  32'd0);
    chk("clrupd_valid", 32'(bus16.snap_valid), 32'd1);
    chk("clrupd_data",  32'(bus16.snap_data),  32'd4);
    bus16.snap_ready = 1'b1;
    step(4'd11);
    chk("clrprime_total", 32'(bus16.total),      32'd0);
    chk("clrprime_valid", 32'(bus16.snap_valid), 32'd0);
    settle(3);
    step(4'd13);
    chk("post_total", 32'(bus16.total),     32'd2);
    chk("post_data",  32'(bus16.snap_data), 32'd2);
    chk("post_t8",    32'(bus8.total),      32'd2);
    settle(3);

    // Drive the 8-bit instance to 255, then one step past it.
    e16 = 2;
    cur = 4'd13;
    while (e16 < 255) begin
      d   = (255 - e16 > 15) ? 15 : (255 - e16);
      dd  = d[3:0];
      cur = cur + dd;
      step(cur);
      e16 = e16 + d;
      chk("ramp_total", 32'(bus16.total), 32'(e16));
      settle(3);
    end
    chk("t8_at_255",  32'(bus8.total),    32'd255);
    chk("ovf8_clear", 32'(bus8.overflow), 32'd0);
    cur = cur + 4'd1;
    step(cur);
    chk("t8_rolled",   32'(bus8.total),     32'd0);
    chk("ovf8_set",    32'(bus8.overflow),  32'd1);
    chk("t16_256",     32'(bus16.total),    32'd256);
    chk("ovf16_clear", 32'(bus16.overflow), 32'd0);
    settle(3);
    cur = cur + 4'd1;
    step(cur);
    chk("t8_one",     32'(bus8.total),    32'd1);
    chk("ovf8_held",  32'(bus8.overflow), 32'd1);
    settle(3);
    pulse_clear();
    chk("ovf8_cleared", 32'(bus8.overflow), 32'd0);
    chk("t8_cleared",   32'(bus8.total),    32'd0);

    // Re-prime, build a nonzero total with a pending snapshot, then reset
    // between clock edges while a new count is still settling.
    cur = cur + 4'd1;
    step(cur);
    settle(3);
    bus16.snap_ready = 1'b0;
    cur = cur + 4'd3;
    step(cur);
    chk("pre_rst_total", 32'(bus16.total),      32'd3);
    chk("pre_rst_valid", 32'(bus16.snap_valid), 32'd1);
    settle(2);
    @(posedge clk);
    #1 bus16.count_in = cur + 4'd5;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_total",  32'(bus16.total),       32'd0);
    chk("arst_valid",  32'(bus16.snap_valid),  32'd0);
    chk("arst_data",   32'(bus16.snap_data),   32'd0);
    chk("arst_wrap",   32'(bus16.wrap_pulse),  32'd0);
    chk("arst_match",  32'(bus16.match_pulse), 32'd0);
    chk("arst_ovf",    32'(bus16.overflow),    32'd0);
    chk("arst_state",  32'(bus16.dbg_state),   32'd0);
    chk("arst_t8",     32'(bus8.total),        32'd0);
    settle(2);
    rst = 1'b0;
    settle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/ripple_count_extender.md
Name: ripple_count_extender

Overview:
- Downstream consumer of the 4-bit ripple counter output.
- Resynchronises the asynchronously settling count into the clk domain and filters ripple transients with a stability check.
- Accumulates modulo increments into a wide total, and flags wrap, overflow and compare-match events.
- Offers total snapshots to the next stage over a valid/ready handshake.

Parameters:
IN_WIDTH, 4, width of incoming ripple count
EXT_WIDTH, 16, width of extended total and match value
STABLE_CYCLES, 2, consecutive identical synchronised samples required before a value is accepted (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
count_in  input  IN_WIDTH  ripple counter output; asynchronous to clk
clear  input  1  synchronous clear of total and flags
match_value  input  EXT_WIDTH  compare value for match_pulse
total  output  EXT_WIDTH  extended accumulated count
wrap_pulse  output  1  one-cycle pulse when accepted count wraps past max
match_pulse  output  1  one-cycle pulse when total becomes equal to match_value
overflow  output  1  sticky; total wrapped past 2^EXT_WIDTH-1
snap_valid  output  1  snapshot available
snap_ready  input  1  downstream accepts snapshot
snap_data  output  EXT_WIDTH  snapshot of total

Behaviour:
- Reset:
  - All registers are cleared and every output is 0.
  - Synchroniser flops s1/s2, candidate, stability counter and last value are 0.
  - FSM enters PRIME.
- Synchroniser: two flops; count_in reaches s2 on the 2nd rising edge.
- Stability filter:
  - If s2 differs from the candidate, the candidate loads s2 and the stability count restarts at 1.
  - If s2 equals the candidate, the count increments, saturating.
  - A value is accepted once, when its count reaches STABLE_CYCLES.
  - Steady count_in updates total at rising edge 2+STABLE_CYCLES after the change.
- FSM:
  - PRIME: the first accepted value loads last_val; no accumulation and no pulses. Next state is TRACK.
  - TRACK: an accepted value v with v != last_val sets delta = (v - last_val) mod 2^IN_WIDTH, adds it with total <= total + delta (mod 2^EXT_WIDTH), and sets last_val <= v.
  - TRACK: an accepted value with v == last_val causes no update.
- wrap_pulse: high for the one cycle after an update where v < last_val.
- overflow: set when total + delta >= 2^EXT_WIDTH. Only clear or rst clears it.
- match_pulse:
  - High for one cycle after an update whose new total == match_value and old total != match_value.
  - A match_value change alone never pulses.
- clear:
  - Next edge sets total=0, overflow=0, wrap/match pulses=0 and FSM=PRIME; the filter is untouched.
  - clear wins over a simultaneous update.
  - A pending snapshot is held; no new snapshot is produced by clear.
- Snapshot handshake:
  - On every update, if snap_valid=0, or snap_valid=1 with snap_ready=1 in the same cycle, snap_data <= new total and snap_valid <= 1.
  - If snap_valid=1 and snap_ready=0, snap_data and snap_valid stay stable; that update's snapshot is discarded.
  - snap_valid falls after a ready cycle with no concurrent update.
- Wide deltas: a count_in jump of more than one step is legal and accumulated modulo (e.g. 3->9 adds 6).
- rst mid-operation: immediate return to reset values regardless of clk.

Test Plan:
- Reset release, count_in steps 0..15 then 0 every 8 cycles -> total 16 after last step, exactly one wrap_pulse, at the 15->0 step; overflow 0.
- count_in glitches 5->7->5 within one cycle, then holds 5 -> no update, total unchanged, snap_valid stays 0.
- match_value=10, counting from primed 0 -> single match_pulse in the cycle after total becomes 10; none at 11.
- EXT_WIDTH=8, count to 255 then one more step -> total 0, overflow 1 held until clear.
- snap_ready=0 over 3 updates (totals 1,2,3) -> snap_data stays 1 with snap_valid=1; snap_ready=1 with no update -> snap_valid drops next cycle.
- clear asserted on the same edge as an accepted update, then rst asserted mid-count -> total 0 after clear (next value primes only); all outputs 0 immediately on rst.
